// File: rtl/pdh_cmd_pkg.sv
// Shared types for the peripheral command dispatcher: opcodes, response
// status codes and the dispatcher FSM state encoding.
package pdh_cmd_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_WRITE = 2'd1,
    OP_CLEAR = 2'd2,
    OP_READ  = 2'd3
  } op_e;

  // Codes 1 and 3 are reserved for future error classes.
  typedef enum logic [1:0] {
    STATUS_OK      = 2'd0,
    STATUS_TIMEOUT = 2'd2
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/cmd_dispatch.sv
// Single-command dispatcher: strobes a peripheral, waits for its callback to
// settle on the expected value (or times out) and returns a one-cycle response.
module cmd_dispatch
  import pdh_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int CALLBACK_WIDTH = 8,
  parameter int MIN_WAIT       = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [1:0]                cmd_op_i,
  input  logic [DATA_WIDTH-1:0]     cmd_data_i,
  output logic                      en_o,
  output logic                      clr_o,
  output logic [DATA_WIDTH-1:0]     data_o,
  input  logic [CALLBACK_WIDTH-1:0] callback_i,
  output logic                      rsp_valid_o,
  output logic [CALLBACK_WIDTH-1:0] rsp_data_o,
  output logic [1:0]                rsp_status_o,
  output logic                      busy_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_WAIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                      state;
  op_e                         op_q;
  logic [CNT_W-1:0]            wait_cnt;
  logic [CALLBACK_WIDTH-1:0]   expected_cb;
  logic                        match;
  logic                        timeout;

  // A WRITE is confirmed by reading its payload back; a CLEAR by reading zero.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    expected_cb = '0;
    if (op_q == OP_WRITE) expected_cb = CALLBACK_WIDTH'(data_o);
    match   = (wait_cnt >= MIN_CNT) && (callback_i == expected_cb);
    timeout = (wait_cnt == LAST_CNT);
  end

  // NOTE: all state and outputs are registered with non-blocking assignments so
  // every branch sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state        <= S_IDLE;
      op_q         <= OP_NOP;
      wait_cnt     <= '0;
      cmd_ready_o  <= 1'b1;
      en_o         <= 1'b0;
      clr_o        <= 1'b0;
      data_o       <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= '0;
      rsp_status_o <= STATUS_OK;
      busy_o       <= 1'b0;
    end else begin
      en_o        <= 1'b0;
      clr_o       <= 1'b0;
      rsp_valid_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            op_q        <= op_e'(cmd_op_i);
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            case (op_e'(cmd_op_i))
              OP_WRITE: begin
                data_o <= cmd_data_i;
                en_o   <= 1'b1;
                state  <= S_ISSUE;
              end
              OP_CLEAR: begin
                data_o <= cmd_data_i;
                clr_o  <= 1'b1;
                state  <= S_ISSUE;
              end
              OP_READ: begin
                rsp_valid_o  <= 1'b1;
                rsp_data_o   <= callback_i;
                rsp_status_o <= STATUS_OK;
                state        <= S_RESP;
              end
              default: begin
                rsp_valid_o  <= 1'b1;
                rsp_data_o   <= '0;
                rsp_status_o <= STATUS_OK;
                state        <= S_RESP;
              end
            endcase
          end
        end

        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        // A qualified match is tested first so it wins over a coincident timeout.
        S_WAIT: begin
          if (match || timeout) begin
            rsp_valid_o  <= 1'b1;
            rsp_data_o   <= callback_i;
            rsp_status_o <= match ? STATUS_OK : STATUS_TIMEOUT;
            state        <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        S_RESP: begin
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          state       <= S_IDLE;
        end

        default: begin
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Self-checking bench for cmd_dispatch: vector table plus scoreboard of
// expected responses, and hand-written reset / back-to-back sequences.
module tb_cmd_dispatch;
  import pdh_cmd_pkg::*;

  localparam int DW   = 8;
  localparam int MINW = 3;
  localparam int TO   = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [1:0]    cmd_op_i = 2'd0;
  logic [DW-1:0] cmd_data_i = '0;
  logic          en_o;
  logic          clr_o;
  logic [DW-1:0] data_o;
  logic [DW-1:0] callback_i = '0;
  logic          rsp_valid_o;
  logic [DW-1:0] rsp_data_o;
  logic [1:0]    rsp_status_o;
  logic          busy_o;

  cmd_dispatch #(
    .DATA_WIDTH(DW), .CALLBACK_WIDTH(DW), .MIN_WAIT(MINW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_data_i(cmd_data_i),
    .en_o(en_o), .clr_o(clr_o), .data_o(data_o), .callback_i(callback_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .rsp_status_o(rsp_status_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] status;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] cb;
    logic [7:0] exp_data;
    logic [1:0] exp_status;
    int         lat;
  } vec_t;

  exp_t       sb[$];
  exp_t       e_mon;
  vec_t       vecs[8];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         en_cnt = 0;
  int         clr_cnt = 0;
  int         rsp_cnt = 0;
  logic [7:0] model_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: strobe accounting and scoreboard comparison of responses.
  always @(negedge clk) begin
    if (en_o === 1'b1) en_cnt++;
    if (clr_o === 1'b1) clr_cnt++;
    if (en_o === 1'b1) check("strobe_excl", clr_o, 0);
    if (rsp_valid_o === 1'b1) begin
      rsp_cnt++;
      if (sb.size() == 0) check("unexpected_rsp", rsp_valid_o, 0);
      else begin
        e_mon = sb.pop_front();
        check("rsp_data", rsp_data_o, e_mon.data);
        check("rsp_status", rsp_status_o, e_mon.status);
        check("rsp_cycle", cyc, e_mon.cyc);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [7:0] ed,
                       input logic [1:0] es, input int lat, input bit push);
    int g;
    g = 0;
    @(negedge clk);
    while (cmd_ready_o !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("ready_before_issue", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_data_i  = d;
    if (push) sb.push_back('{data: ed, status: es, cyc: cyc + lat});
    if (op == OP_WRITE || op == OP_CLEAR) model_data = d;
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int g = 0; g < 100 && sb.size() != 0; g++) @(posedge clk);
    @(negedge clk);
    check("rsp_outstanding", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int e0, c0, r0, acc;

    vecs[0] = '{OP_NOP,   8'h44, 8'h11, 8'h00, STATUS_OK,      1};
    vecs[1] = '{OP_READ,  8'h00, 8'h5A, 8'h5A, STATUS_OK,      1};
    vecs[2] = '{OP_WRITE, 8'h00, 8'h00, 8'h00, STATUS_OK,      MINW + 3};
    vecs[3] = '{OP_CLEAR, 8'h12, 8'h00, 8'h00, STATUS_OK,      MINW + 3};
    vecs[4] = '{OP_CLEAR, 8'h77, 8'h3C, 8'h3C, STATUS_TIMEOUT, TO + 2};
    vecs[5] = '{OP_WRITE, 8'h55, 8'hAA, 8'hAA, STATUS_TIMEOUT, TO + 2};
    vecs[6] = '{OP_WRITE, 8'h3C, 8'h3C, 8'h3C, STATUS_OK,      MINW + 3};
    vecs[7] = '{OP_READ,  8'hC3, 8'hFF, 8'hFF, STATUS_OK,      1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_en", en_o, 0);
    check("rst_clr", clr_o, 0);
    check("rst_data", data_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_data", rsp_data_o, 0);
    check("rst_rsp_status", rsp_status_o, 0);
    check("rst_busy", busy_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready_o, 1);

    // Vector table
    foreach (vecs[i]) begin
      callback_i = vecs[i].cb;
      e0 = en_cnt;
      c0 = clr_cnt;
      issue(vecs[i].op, vecs[i].data, vecs[i].exp_data, vecs[i].exp_status, vecs[i].lat, 1'b1);
      wait_rsp();
      check("data_o", data_o, model_data);
      check("en_pulses", en_cnt - e0, (vecs[i].op == OP_WRITE) ? 1 : 0);
      check("clr_pulses", clr_cnt - c0, (vecs[i].op == OP_CLEAR) ? 1 : 0);
      repeat (2) @(negedge clk);
      check("rsp_hold", rsp_data_o, vecs[i].exp_data);
      check("idle_ready", cmd_ready_o, 1);
    end

    // WRITE 0xA5 against a peripheral that settles four cycles after en_o
    callback_i = 8'h00;
    e0 = en_cnt;
    issue(OP_WRITE, 8'hA5, 8'hA5, STATUS_OK, 6, 1'b1);
    check("en_seen", en_o, 1);
    repeat (4) @(negedge clk);
    callback_i = 8'hA5;
    check("data_o_a5", data_o, 8'hA5);
    wait_rsp();
    check("en_pulses_a5", en_cnt - e0, 1);

    // Reset in the middle of WAIT aborts with no response and no strobe
    callback_i = 8'h00;
    issue(OP_WRITE, 8'h99, 8'h00, STATUS_OK, 0, 1'b0);
    repeat (5) @(negedge clk);
    check("busy_in_wait", busy_o, 1);
    rst_i = 1'b1;
    @(negedge clk);
    model_data = '0;
    r0 = rsp_cnt;
    e0 = en_cnt;
    c0 = clr_cnt;
    check("abort_en", en_o, 0);
    check("abort_clr", clr_o, 0);
    check("abort_data", data_o, model_data);
    check("abort_rsp_valid", rsp_valid_o, 0);
    check("abort_rsp_data", rsp_data_o, 0);
    check("abort_rsp_status", rsp_status_o, 0);
    check("abort_busy", busy_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    check("abort_ready", cmd_ready_o, 1);
    repeat (20) @(negedge clk);
    check("abort_no_rsp", rsp_cnt - r0, 0);
    check("abort_no_strobe", (en_cnt - e0) + (clr_cnt - c0), 0);

    // cmd_valid_i held high: back-to-back READs, one accept every two cycles
    callback_i = 8'h21;
    r0 = rsp_cnt;
    acc = 0;
    cmd_op_i = OP_READ;
    cmd_data_i = 8'h00;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (cmd_ready_o) begin
        sb.push_back('{data: 8'h21, status: STATUS_OK, cyc: cyc + 1});
        acc++;
      end
      check("ready_only_idle", cmd_ready_o, !busy_o);
      @(negedge clk);
    end
    cmd_valid_i = 1'b0;
    wait_rsp();
    check("b2b_read_accepts", acc, 6);
    check("b2b_read_rsps", rsp_cnt - r0, 6);

    // Held-valid WRITEs: each one matches at WAIT count MIN_WAIT
    callback_i = 8'h3C;
    r0 = rsp_cnt;
    e0 = en_cnt;
    acc = 0;
    cmd_op_i = OP_WRITE;
    cmd_data_i = 8'h3C;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 21; i++) begin
      if (cmd_ready_o) begin
        sb.push_back('{data: 8'h3C, status: STATUS_OK, cyc: cyc + MINW + 3});
        acc++;
      end
      check("ready_only_idle_w", cmd_ready_o, !busy_o);
      @(negedge clk);
    end
    cmd_valid_i = 1'b0;
    wait_rsp();
    check("b2b_write_accepts", acc, 3);
    check("b2b_write_rsps", rsp_cnt - r0, 3);
    check("b2b_write_strobes", en_cnt - e0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule

// File: doc/cmd_dispatch.md
CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, strobe payload width; CALLBACK_WIDTH, default 8, peripheral callback width, equal to DATA_WIDTH; MIN_WAIT, default 3, cycles after a strobe during which the callback is ignored; TIMEOUT_CYCLES, default 1024, maximum WAIT cycles, at least MIN_WAIT.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 cmd_valid_i  in  1  command valid.
REQ-005 cmd_ready_o  out  1  command accept.
REQ-006 cmd_op_i  in  2  opcode: NOP=0, WRITE=1, CLEAR=2, READ=3.
REQ-007 cmd_data_i  in  DATA_WIDTH  command payload.
REQ-008 en_o  out  1  one-cycle enable strobe to the peripheral.
REQ-009 clr_o  out  1  one-cycle clear strobe to the peripheral.
REQ-010 data_o  out  DATA_WIDTH  payload to the peripheral.
REQ-011 callback_i  in  CALLBACK_WIDTH  peripheral readback.
REQ-012 rsp_valid_o  out  1  one-cycle response pulse.
REQ-013 rsp_data_o  out  CALLBACK_WIDTH  callback value captured at completion.
REQ-014 rsp_status_o  out  2  OK=0, TIMEOUT=2; other codes are reserved.
REQ-015 busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have four states (IDLE, ISSUE, WAIT, RESP), and all outputs SHALL be registered.
REQ-017 cmd_ready_o SHALL be 1 only in IDLE, and a command SHALL be accepted on the edge where cmd_valid_i and cmd_ready_o are both 1.
REQ-018 On acceptance, op and data SHALL be captured; captured data SHALL drive data_o from the next cycle and hold until the next accepted WRITE or CLEAR.
REQ-019 NOP SHALL go to RESP with rsp_data_o=0, status OK, and no strobe.
REQ-020 READ SHALL go to RESP with rsp_data_o equal to callback_i sampled on the accept edge, status OK, and no strobe.
REQ-021 WRITE and CLEAR SHALL go to ISSUE, where en_o=1 (WRITE) or clr_o=1 (CLEAR) for exactly one cycle, then go to WAIT with the wait counter at 0.
REQ-022 In WAIT, the counter SHALL increment each cycle; the expected callback SHALL be the captured data for WRITE and 0 for CLEAR.
REQ-023 A match SHALL qualify only when counter >= MIN_WAIT and callback_i == expected; a qualified match SHALL go to RESP with status OK and rsp_data_o=callback_i.
REQ-024 When counter == TIMEOUT_CYCLES-1 with no qualified match, the FSM SHALL go to RESP with status TIMEOUT and rsp_data_o=callback_i.
REQ-025 If a match and timeout occur in the same cycle, OK SHALL win.
REQ-026 RESP SHALL assert rsp_valid_o for exactly one cycle, then return to IDLE; the earliest next accept SHALL be the cycle after RESP.
REQ-027 rsp_data_o and rsp_status_o SHALL hold their values until the next response.
REQ-028 Latency for a match at WAIT count k SHALL be accept, ISSUE, k+1 WAIT cycles, then RESP.
REQ-029 The counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide and SHALL never wrap.
REQ-030 cmd_valid_i SHALL be ignored outside IDLE, with no queuing.
REQ-031 en_o and clr_o SHALL never both be 1.

Reset
REQ-032 Reset SHALL set the state to IDLE, and cmd_ready_o SHALL be 1 the cycle after reset deasserts.
REQ-033 Reset SHALL clear en_o, clr_o, data_o, rsp_valid_o, rsp_data_o, rsp_status_o, busy_o and the counter to 0.
REQ-034 Reset during ISSUE or WAIT SHALL abort the command with no response pulse and no further strobe.

Structure
REQ-035 Package pdh_cmd_pkg SHALL hold the opcode enum, the status enum and the FSM state typedef.
REQ-036 The block SHALL be a single module with the counter inline and no sub-module.

Verification
REQ-037 WRITE 0xA5, with a peripheral model whose callback becomes 0xA5 four cycles after en_o: the bench SHALL see one en_o pulse, data_o=0xA5, and rsp_valid_o with OK and 0xA5.
REQ-038 WRITE 0x00 with callback already 0: the bench SHALL see no response before WAIT count MIN_WAIT, then OK with rsp_data_o=0x00.
REQ-039 CLEAR with the callback stuck at 0x3C and TIMEOUT_CYCLES=16: the bench SHALL see one clr_o pulse, then rsp_valid_o 17 cycles after ISSUE with TIMEOUT and 0x3C.
REQ-040 READ with callback_i=0x5A: the bench SHALL see rsp_valid_o the cycle after accept with OK and 0x5A, and en_o and clr_o at 0 throughout.
REQ-041 Reset asserted mid-WAIT: the bench SHALL see no rsp_valid_o, outputs at 0, and cmd_ready_o=1 after reset release.
REQ-042 cmd_valid_i held high through back-to-back commands: the bench SHALL see acceptance only in IDLE and exactly one response per accepted command.
